// File: rtl/uart_tx.sv
// 8N1 UART transmitter: latches a byte on send and shifts it out LSB-first.
// tx and tx_done are bits of the state encoding, so both are registered outputs.
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       tx_done
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

    // Encoding is {one-hot[4:0], tx, tx_done}.
    typedef enum logic [6:0] {
        IDLE  = 7'b00001_11,
        START = 7'b00010_00,
        TX_0  = 7'b00100_00,
        TX_1  = 7'b01000_10,
        STOP  = 7'b10000_10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);
    assign tx      = state[1];
    assign tx_done = state[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        case (state)
            IDLE: begin
                if (send) begin
                    state_next   = START;
                    shift_next   = data;
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = shift_reg[0] ? TX_1 : TX_0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            TX_0, TX_1: begin
                if (bit_end) begin
                    cnt_next     = '0;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        // shift_reg[0] is the bit on the line; [1] is the next one.
                        shift_next = shift_reg >> 1;
                        state_next = shift_reg[1] ? TX_1 : TX_0;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                bit_idx_next = '0;
                shift_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 2 clock cycles per bit (10 ns clock).
// Each test task drives its scenario and compares state/tx/tx_done inline.
module tb_uart_tx;

    localparam logic [6:0] S_IDLE  = 7'b00001_11;
    localparam logic [6:0] S_START = 7'b00010_00;
    localparam logic [6:0] S_TX_0  = 7'b00100_00;
    localparam logic [6:0] S_TX_1  = 7'b01000_10;
    localparam logic [6:0] S_STOP  = 7'b10000_10;

    logic       clk;
    logic       rst;
    logic       send;
    logic [7:0] data;
    logic       tx;
    logic       tx_done;

    int n_cmp;
    int n_err;

    // One sample per bit period: index 0 is START, 1..8 data, 9 STOP, 10 IDLE.
    logic [6:0] cap_state [11];
    logic       cap_tx    [11];
    logic       cap_done  [11];

    uart_tx #(
        .CLK_FREQ (50_000_000),
        .BAUD_RATE(25_000_000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .send   (send),
        .data   (data),
        .tx     (tx),
        .tx_done(tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] exp_state(input logic [7:0] b, input int i);
        if (i == 0) return S_START;
        if (i <= 8) return b[i-1] ? S_TX_1 : S_TX_0;
        if (i == 9) return S_STOP;
        return S_IDLE;
    endfunction

    function automatic logic exp_tx(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    // Issues send at the next edge and records the frame; called from a negedge with DUT in IDLE.
    task automatic run_frame(input logic [7:0] b, input logic [7:0] b_after,
                             input bit pulse_send, input bit hold_send);
        data = b;
        send = 1'b1;
        @(negedge clk);
        cap_state[0] = dut.state;
        cap_tx[0]    = tx;
        cap_done[0]  = tx_done;
        send = hold_send;
        data = b_after;
        for (int i = 1; i < 11; i++) begin
            repeat (2) @(negedge clk);
            cap_state[i] = dut.state;
            cap_tx[i]    = tx;
            cap_done[i]  = tx_done;
            send = hold_send | (pulse_send && i >= 2 && i <= 6);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        send = 1'b0;
        data = 8'h00;
        @(negedge clk);
        n_cmp++;
        if (dut.state !== S_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", dut.state, S_IDLE);
        end
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        n_cmp++;
        if (tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx_done: got %b want 1", tx_done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame();
        run_frame(8'h55, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (cap_state[i] !== exp_state(8'h55, i)) begin
                n_err++;
                $display("FAIL frame_state[%0d]: got %b want %b", i, cap_state[i], exp_state(8'h55, i));
            end
            n_cmp++;
            if (cap_tx[i] !== exp_tx(8'h55, i)) begin
                n_err++;
                $display("FAIL frame_tx[%0d]: got %b want %b", i, cap_tx[i], exp_tx(8'h55, i));
            end
            n_cmp++;
            if (cap_done[i] !== (i == 10)) begin
                n_err++;
                $display("FAIL frame_tx_done[%0d]: got %b want %b", i, cap_done[i], (i == 10));
            end
        end
    endtask

    task automatic test_data_capture();
        logic [7:0] bits;
        run_frame(8'h55, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) bits[i] = cap_tx[i+1];
        n_cmp++;
        if (bits !== 8'h55) begin
            n_err++;
            $display("FAIL capture_bits: got %h want 55", bits);
        end
        n_cmp++;
        if (cap_tx[0] !== 1'b0 || cap_tx[9] !== 1'b1) begin
            n_err++;
            $display("FAIL capture_framing: start %b stop %b want 0 1", cap_tx[0], cap_tx[9]);
        end
    endtask

    task automatic test_mid_reset();
        data = 8'hA3;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dut.state !== S_TX_1) begin
            n_err++;
            $display("FAIL midrst_pre_state: got %b want %b", dut.state, S_TX_1);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut.state !== S_IDLE || tx !== 1'b1 || tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_idle: got state %b tx %b done %b want %b 1 1", dut.state, tx, tx_done, S_IDLE);
        end
        rst = 1'b1;
        @(negedge clk);
        run_frame(8'hA3, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (cap_state[i] !== exp_state(8'hA3, i)) begin
                n_err++;
                $display("FAIL midrst_frame_state[%0d]: got %b want %b", i, cap_state[i], exp_state(8'hA3, i));
            end
        end
    endtask

    task automatic test_send_ignored();
        run_frame(8'h3C, 8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            n_cmp++;
            if (cap_state[i] !== exp_state(8'h3C, i)) begin
                n_err++;
                $display("FAIL ignored_state[%0d]: got %b want %b", i, cap_state[i], exp_state(8'h3C, i));
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut.state !== S_IDLE || tx_done !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_no_second_frame: got state %b done %b want %b 1", dut.state, tx_done, S_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            run_frame(8'h0F, 8'h0F, 1'b0, 1'b1);
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if (cap_state[i] !== exp_state(8'h0F, i)) begin
                    n_err++;
                    $display("FAIL b2b_state[f%0d][%0d]: got %b want %b", f, i, cap_state[i], exp_state(8'h0F, i));
                end
            end
        end
        // The sample after the second frame's single IDLE cycle must be a third START.
        @(negedge clk);
        n_cmp++;
        if (dut.state !== S_START) begin
            n_err++;
            $display("FAIL b2b_restart: got %b want %b", dut.state, S_START);
        end
        send = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (dut.state !== S_IDLE) begin
            n_err++;
            $display("FAIL b2b_drain: got %b want %b", dut.state, S_IDLE);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        send  = 1'b0;
        data  = 8'h00;
        test_reset();
        test_frame();
        test_data_capture();
        test_mid_reset();
        test_send_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
